pw_trigger_sequencer: RTL and testbench

- Converts the pattern-matcher trigger-match pulse into a programmable trigger waveform for the ChipWhisperer trigger pin (cw_trig).
- Waveform: delay from match, pulse width, pulse count and inter-pulse gap, all in fe_clk cycles.
- Sits directly downstream of pw_pattern_matcher (consumes its trigger match) and upstream of the cw_trig output.
- Configuration and status are driven from and read back through reg_pw.

---
 rtl/pw_trigger_pkg.sv | 20 ++
 rtl/pw_trigger_sequencer_if.sv | 35 +++
 rtl/pw_trig_down_counter.sv | 30 +++
 rtl/pw_trigger_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_pw_trigger_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pw_trigger_pkg.sv
// pw_trigger_pkg
//   Shared types and default widths for the trigger sequencer.
//   - state_e       : sequencer FSM states
//   - P_*_WIDTH     : default counter widths (cycles / pulses)
package pw_trigger_pkg;

  localparam int P_DELAY_WIDTH = 20;
  localparam int P_PULSE_WIDTH = 17;
  localparam int P_COUNT_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_PULSE = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/pw_trigger_sequencer_if.sv
// pw_trigger_sequencer_if
//   Configuration / match / status bundle between the register block and
//   pattern matcher (master side) and the trigger sequencer (slave side).
//   Inputs : I_arm, I_match, I_delay, I_width, I_gap, I_num_pulses
//   Outputs: O_trigger, O_busy, O_done, O_pulse_count
interface pw_trigger_sequencer_if
  import pw_trigger_pkg::*;
#(
  parameter int pDELAY_WIDTH = P_DELAY_WIDTH,
  parameter int pPULSE_WIDTH = P_PULSE_WIDTH,
  parameter int pCOUNT_WIDTH = P_COUNT_WIDTH
);

  logic                    I_arm;
  logic                    I_match;
  logic [pDELAY_WIDTH-1:0] I_delay;
  logic [pPULSE_WIDTH-1:0] I_width;
  logic [pDELAY_WIDTH-1:0] I_gap;
  logic [pCOUNT_WIDTH-1:0] I_num_pulses;
  logic                    O_trigger;
  logic                    O_busy;
  logic                    O_done;
  logic [pCOUNT_WIDTH-1:0] O_pulse_count;

  modport master (
    output I_arm, I_match, I_delay, I_width, I_gap, I_num_pulses,
    input  O_trigger, O_busy, O_done, O_pulse_count
  );

  modport slave (
    input  I_arm, I_match, I_delay, I_width, I_gap, I_num_pulses,
    output O_trigger, O_busy, O_done, O_pulse_count
  );

endinterface

// File: rtl/pw_trig_down_counter.sv
// pw_trig_down_counter
//   Loadable down-counter with zero flag. Saturates at zero (never wraps).
//   Ports: fe_clk, reset_i (async, active high)
//          i_load / i_value : load a new count (has priority over i_dec)
//          i_dec            : decrement by one while non-zero
//          o_zero           : count is zero
module pw_trig_down_counter #(
  parameter int pWIDTH = 20
) (
  input  logic              fe_clk,
  input  logic              reset_i,
  input  logic              i_load,
  input  logic [pWIDTH-1:0] i_value,
  input  logic              i_dec,
  output logic              o_zero
);

  localparam logic [pWIDTH-1:0] ONE = 1;

  logic [pWIDTH-1:0] r_count;

  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i)                        r_count <= '0;
    else if (i_load)                    r_count <= i_value;
    else if (i_dec && (r_count != '0))  r_count <= r_count - ONE;
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/pw_trigger_sequencer.sv
// pw_trigger_sequencer
//   Turns a single-cycle pattern-match pulse into a programmable trigger
//   waveform: delay, then num_pulses pulses of width cycles separated by
//   gap cycles. Configuration is captured at the accepted match.
//   Ports: fe_clk, reset_i (async, active high)
//          bus (slave) : I_arm, I_match, I_delay, I_width, I_gap,
//                        I_num_pulses -> O_trigger, O_busy, O_done,
//                        O_pulse_count (all outputs registered)
module pw_trigger_sequencer
  import pw_trigger_pkg::*;
#(
  parameter int pDELAY_WIDTH = P_DELAY_WIDTH,
  parameter int pPULSE_WIDTH = P_PULSE_WIDTH,
  parameter int pCOUNT_WIDTH = P_COUNT_WIDTH
) (
  input logic                   fe_clk,
  input logic                   reset_i,
  pw_trigger_sequencer_if.slave bus
);

  localparam logic [pDELAY_WIDTH-1:0] D_ONE = 1;
  localparam logic [pPULSE_WIDTH-1:0] W_ONE = 1;
  localparam logic [pCOUNT_WIDTH-1:0] C_ONE = 1;

  state_e                  r_state;
  logic [pPULSE_WIDTH-1:0] r_width_m1;
  logic [pDELAY_WIDTH-1:0] r_gap_m1;
  logic [pCOUNT_WIDTH-1:0] r_num;
  logic                    r_trigger;
  logic                    r_busy;
  logic                    r_done;
  logic [pCOUNT_WIDTH-1:0] r_pulse_count;

  logic [pPULSE_WIDTH-1:0] w_in_width_m1;
  logic [pDELAY_WIDTH-1:0] w_in_gap_m1;
  logic [pDELAY_WIDTH-1:0] w_in_delay_m1;
  logic [pCOUNT_WIDTH-1:0] w_in_num;
  logic                    w_delay_zero;
  logic                    w_start;
  logic                    w_abort;
  logic                    w_last;
  logic                    w_dg_zero;
  logic                    w_w_zero;
  logic                    w_dg_load;
  logic                    w_dg_dec;
  logic [pDELAY_WIDTH-1:0] w_dg_val;
  logic                    w_w_load;
  logic                    w_w_dec;
  logic [pPULSE_WIDTH-1:0] w_w_val;

  // Timers count "remaining cycles minus one": a state lasting N cycles is
  // loaded with N-1 on entry and exits on the edge where the count is zero.
  // Zero width/gap/count are promoted to one.
  assign w_in_width_m1 = (bus.I_width == '0) ? '0 : bus.I_width - W_ONE;
  assign w_in_gap_m1   = (bus.I_gap   == '0) ? '0 : bus.I_gap   - D_ONE;
  assign w_in_delay_m1 = bus.I_delay - D_ONE;
  assign w_in_num      = (bus.I_num_pulses == '0) ? C_ONE : bus.I_num_pulses;
  assign w_delay_zero  = (bus.I_delay == '0);

  assign w_start = (r_state == ST_ARMED) && bus.I_arm && bus.I_match;
  assign w_abort = !bus.I_arm &&
                   ((r_state == ST_DELAY) || (r_state == ST_PULSE) || (r_state == ST_GAP));
  assign w_last  = (r_pulse_count == r_num);

  // Timer control. The delay timer doubles as the gap timer since the two
  // intervals never overlap.
  always_comb begin
    w_dg_load = 1'b0;
    w_dg_val  = '0;
    w_w_load  = 1'b0;
    w_w_val   = '0;
    if (w_start) begin
      if (w_delay_zero) begin
        w_w_load = 1'b1;
        w_w_val  = w_in_width_m1;
      end else begin
        w_dg_load = 1'b1;
        w_dg_val  = w_in_delay_m1;
      end
    end else if (bus.I_arm) begin
      case (r_state)
        ST_DELAY, ST_GAP: if (w_dg_zero) begin
          w_w_load = 1'b1;
          w_w_val  = r_width_m1;
        end
        ST_PULSE: if (w_w_zero && !w_last) begin
          w_dg_load = 1'b1;
          w_dg_val  = r_gap_m1;
        end
        default: ;
      endcase
    end
  end

  assign w_dg_dec = (r_state == ST_DELAY) || (r_state == ST_GAP);
  assign w_w_dec  = (r_state == ST_PULSE);

  pw_trig_down_counter #(.pWIDTH(pDELAY_WIDTH)) u_dg_timer (
    .fe_clk  (fe_clk),
    .reset_i (reset_i),
    .i_load  (w_dg_load),
    .i_value (w_dg_val),
    .i_dec   (w_dg_dec),
    .o_zero  (w_dg_zero)
  );

  pw_trig_down_counter #(.pWIDTH(pPULSE_WIDTH)) u_w_timer (
    .fe_clk  (fe_clk),
    .reset_i (reset_i),
    .i_load  (w_w_load),
    .i_value (w_w_val),
    .i_dec   (w_w_dec),
    .o_zero  (w_w_zero)
  );

  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      r_state       <= ST_IDLE;
      r_width_m1    <= '0;
      r_gap_m1      <= '0;
      r_num         <= '0;
      r_trigger     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pulse_count <= '0;
    end else if (w_abort) begin
      // Arm dropped mid-sequence: stop cleanly, keep the pulse tally.
      r_state   <= ST_IDLE;
      r_trigger <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.I_arm) r_state <= ST_ARMED;
        ST_ARMED: begin
          if (!bus.I_arm) begin
            r_state <= ST_IDLE;
          end else if (bus.I_match) begin
            r_width_m1 <= w_in_width_m1;
            r_gap_m1   <= w_in_gap_m1;
            r_num      <= w_in_num;
            r_busy     <= 1'b1;
            if (w_delay_zero) begin
              r_state       <= ST_PULSE;
              r_trigger     <= 1'b1;
              r_pulse_count <= C_ONE;
            end else begin
              r_state       <= ST_DELAY;
              r_pulse_count <= '0;
            end
          end
        end
        ST_DELAY, ST_GAP: if (w_dg_zero) begin
          r_state       <= ST_PULSE;
          r_trigger     <= 1'b1;
          r_pulse_count <= r_pulse_count + C_ONE;
        end
        ST_PULSE: if (w_w_zero) begin
          r_trigger <= 1'b0;
          if (w_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_GAP;
          end
        end
        ST_DONE: if (!bus.I_arm) begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.O_trigger     = r_trigger;
  assign bus.O_busy        = r_busy;
  assign bus.O_done        = r_done;
  assign bus.O_pulse_count = r_pulse_count;

endmodule

// File: tb/tb_pw_trigger_sequencer.sv
// tb_pw_trigger_sequencer
//   Directed scenarios plus randomized sequences checked against a
//   closed-form waveform model. Cycle 0 of each run is the match cycle.
module tb_pw_trigger_sequencer;

  localparam int DW = 20;
  localparam int PW = 17;
  localparam int CW = 4;
  localparam int MAXC = 128;

  logic fe_clk  = 1'b0;
  logic reset_i = 1'b0;

  pw_trigger_sequencer_if #(.pDELAY_WIDTH(DW), .pPULSE_WIDTH(PW), .pCOUNT_WIDTH(CW)) bus();

  pw_trigger_sequencer #(.pDELAY_WIDTH(DW), .pPULSE_WIDTH(PW), .pCOUNT_WIDTH(CW)) dut (
    .fe_clk  (fe_clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 fe_clk = ~fe_clk;

  int errors = 0;
  int checks = 0;

  logic [2:0]    obs_st  [0:MAXC-1];  // {trigger, busy, done}
  logic [CW-1:0] obs_cnt [0:MAXC-1];

  // Reference: pulse p occupies cycles [1+d+p*(w+g), +w) relative to match.
  // After an abort in cycle a, everything is low and the tally freezes at
  // the number of pulses started by cycle a. ecnt<0 means "not predicted".
  function automatic void model(input int d, w, g, n, abrt, c,
                                output logic [2:0] est, output int ecnt);
    int wr, gr, nr, per, e_end, t, cc;
    logic et, eb, ed;
    wr = (w == 0) ? 1 : w;
    gr = (g == 0) ? 1 : g;
    nr = (n == 0) ? 1 : n;
    per = wr + gr;
    e_end = 1 + d + nr*wr + (nr-1)*gr;
    t = c - 1 - d;
    et = (t >= 0) && ((t / per) < nr) && ((t % per) < wr);
    eb = (c >= 1) && (c < e_end);
    ed = (c >= e_end);
    cc = c;
    if (abrt >= 0 && c > abrt) begin
      et = 1'b0; eb = 1'b0; ed = 1'b0; cc = abrt;
    end
    ecnt = -1;
    if (cc >= 1) begin
      ecnt = 0;
      for (int p = 0; p < nr; p++) if (1 + d + p*per <= cc) ecnt++;
    end
    est = {et, eb, ed};
  endfunction

  // Drive one sequence starting with a match in cycle 0 and record outputs.
  // m2: extra match cycle, chg: cycle where all config inputs change,
  // abrt: cycle where I_arm falls (-1 = never). Entered/left at posedge+1.
  task automatic run_seq(input int d, w, g, n, m2, chg, abrt, ncyc);
    bus.I_delay      = DW'(d);
    bus.I_width      = PW'(w);
    bus.I_gap        = DW'(g);
    bus.I_num_pulses = CW'(n);
    for (int c = 0; c < ncyc; c++) begin
      bus.I_match = (c == 0) || (c == m2);
      if (c == chg) begin
        bus.I_width = PW'(7); bus.I_gap = DW'(1);
        bus.I_num_pulses = CW'(9); bus.I_delay = '0;
      end
      if (c == abrt) bus.I_arm = 1'b0;
      @(negedge fe_clk);
      obs_st[c]  = {bus.O_trigger, bus.O_busy, bus.O_done};
      obs_cnt[c] = bus.O_pulse_count;
      @(posedge fe_clk); #1;
    end
    bus.I_match = 1'b0;
  endtask

  task automatic rearm();
    bus.I_arm = 1'b0;
    repeat (2) begin @(posedge fe_clk); #1; end
    bus.I_arm = 1'b1;
    repeat (2) begin @(posedge fe_clk); #1; end
  endtask

  task automatic test_reset();
    #2 reset_i = 1'b1;
    #1;
    checks++;
    if ({bus.O_trigger, bus.O_busy, bus.O_done, bus.O_pulse_count} !== '0) begin
      errors++;
      $display("FAIL reset_async outputs got %b%b%b cnt=%0d exp 000 cnt=0",
               bus.O_trigger, bus.O_busy, bus.O_done, bus.O_pulse_count);
    end
    bus.I_arm = 1'b1;
    bus.I_match = 1'b1;
    repeat (3) @(negedge fe_clk);
    checks++;
    if ({bus.O_trigger, bus.O_busy, bus.O_done, bus.O_pulse_count} !== '0) begin
      errors++;
      $display("FAIL reset_held outputs got %b%b%b cnt=%0d exp 000 cnt=0",
               bus.O_trigger, bus.O_busy, bus.O_done, bus.O_pulse_count);
    end
    bus.I_match = 1'b0;
    @(posedge fe_clk); #1;
    reset_i = 1'b0;
  endtask

  task automatic test_single_pulse();
    logic [2:0] est; int ecnt;
    run_seq(5, 3, 0, 1, -1, -1, -1, 14);
    for (int c = 0; c < 14; c++) begin
      model(5, 3, 0, 1, -1, c, est, ecnt);
      checks++;
      if (obs_st[c] !== est) begin
        errors++; $display("FAIL single trig/busy/done c=%0d got %b exp %b", c, obs_st[c], est);
      end
      if (ecnt >= 0) begin
        checks++;
        if (obs_cnt[c] !== ecnt[CW-1:0]) begin
          errors++; $display("FAIL single count c=%0d got %0d exp %0d", c, obs_cnt[c], ecnt);
        end
      end
    end
    // Done must survive until arm falls, then clear one cycle later.
    bus.I_arm = 1'b0;
    @(negedge fe_clk);
    checks++;
    if (bus.O_done !== 1'b1) begin
      errors++; $display("FAIL done_sticky got %b exp 1", bus.O_done);
    end
    @(negedge fe_clk);
    checks++;
    if (bus.O_done !== 1'b0) begin
      errors++; $display("FAIL done_clear got %b exp 0", bus.O_done);
    end
    @(posedge fe_clk); #1;
    rearm();
  endtask

  task automatic test_zero();
    logic [2:0] est; int ecnt;
    run_seq(0, 0, 0, 0, -1, -1, -1, 6);
    for (int c = 0; c < 6; c++) begin
      model(0, 0, 0, 0, -1, c, est, ecnt);
      checks++;
      if (obs_st[c] !== est) begin
        errors++; $display("FAIL zero trig/busy/done c=%0d got %b exp %b", c, obs_st[c], est);
      end
      if (ecnt >= 0) begin
        checks++;
        if (obs_cnt[c] !== ecnt[CW-1:0]) begin
          errors++; $display("FAIL zero count c=%0d got %0d exp %0d", c, obs_cnt[c], ecnt);
        end
      end
    end
    rearm();
  endtask

  task automatic test_train();
    logic [2:0] est; int ecnt;
    run_seq(2, 2, 3, 3, -1, -1, -1, 18);
    for (int c = 0; c < 18; c++) begin
      model(2, 2, 3, 3, -1, c, est, ecnt);
      checks++;
      if (obs_st[c] !== est) begin
        errors++; $display("FAIL train trig/busy/done c=%0d got %b exp %b", c, obs_st[c], est);
      end
      if (ecnt >= 0) begin
        checks++;
        if (obs_cnt[c] !== ecnt[CW-1:0]) begin
          errors++; $display("FAIL train count c=%0d got %0d exp %0d", c, obs_cnt[c], ecnt);
        end
      end
    end
    rearm();
  endtask

  task automatic test_back_to_back();
    logic [2:0] est; int ecnt;
    // Second match in cycle 5 and config change in cycle 2 must not matter.
    run_seq(2, 2, 3, 3, 5, 2, -1, 18);
    for (int c = 0; c < 18; c++) begin
      model(2, 2, 3, 3, -1, c, est, ecnt);
      checks++;
      if (obs_st[c] !== est) begin
        errors++; $display("FAIL retrig trig/busy/done c=%0d got %b exp %b", c, obs_st[c], est);
      end
      if (ecnt >= 0) begin
        checks++;
        if (obs_cnt[c] !== ecnt[CW-1:0]) begin
          errors++; $display("FAIL retrig count c=%0d got %0d exp %0d", c, obs_cnt[c], ecnt);
        end
      end
    end
    rearm();
  endtask

  task automatic test_abort();
    logic [2:0] est; int ecnt;
    // Second gap spans cycles 10..12; arm falls in cycle 11.
    run_seq(2, 2, 3, 4, -1, -1, 11, 18);
    for (int c = 0; c < 18; c++) begin
      model(2, 2, 3, 4, 11, c, est, ecnt);
      checks++;
      if (obs_st[c] !== est) begin
        errors++; $display("FAIL abort trig/busy/done c=%0d got %b exp %b", c, obs_st[c], est);
      end
      if (ecnt >= 0) begin
        checks++;
        if (obs_cnt[c] !== ecnt[CW-1:0]) begin
          errors++; $display("FAIL abort count c=%0d got %0d exp %0d", c, obs_cnt[c], ecnt);
        end
      end
    end
    // Match with arm low: nothing happens, tally still holds 2.
    run_seq(0, 1, 1, 1, -1, -1, 0, 8);
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (obs_st[c] !== 3'b000 || obs_cnt[c] !== CW'(2)) begin
        errors++; $display("FAIL abort_disarmed c=%0d got st=%b cnt=%0d exp st=000 cnt=2",
                           c, obs_st[c], obs_cnt[c]);
      end
    end
    // Arm falls in the same cycle as the match: abort wins.
    rearm();
    run_seq(0, 1, 1, 1, -1, -1, 0, 6);
    for (int c = 0; c < 6; c++) begin
      model(0, 1, 1, 1, 0, c, est, ecnt);
      checks++;
      if (obs_st[c] !== est) begin
        errors++; $display("FAIL abort_same_cycle c=%0d got %b exp %b", c, obs_st[c], est);
      end
    end
    rearm();
  endtask

  task automatic test_random();
    logic [2:0] est; int ecnt;
    int d, w, g, n, wr, gr, nr, e_end, m2, chg, abrt, ncyc;
    for (int it = 0; it < 24; it++) begin
      d = $urandom_range(0, 6); w = $urandom_range(0, 4);
      g = $urandom_range(0, 4); n = $urandom_range(0, 5);
      wr = (w == 0) ? 1 : w; gr = (g == 0) ? 1 : g; nr = (n == 0) ? 1 : n;
      e_end = 1 + d + nr*wr + (nr-1)*gr;
      m2   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, e_end) : -1;
      chg  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, e_end) : -1;
      abrt = ($urandom_range(0, 2) == 0 && e_end > 1) ? $urandom_range(1, e_end-1) : -1;
      ncyc = e_end + 3;
      run_seq(d, w, g, n, m2, chg, abrt, ncyc);
      for (int c = 0; c < ncyc; c++) begin
        model(d, w, g, n, abrt, c, est, ecnt);
        checks++;
        if (obs_st[c] !== est) begin
          errors++; $display("FAIL random it=%0d d=%0d w=%0d g=%0d n=%0d ab=%0d c=%0d got %b exp %b",
                             it, d, w, g, n, abrt, c, obs_st[c], est);
        end
        if (ecnt >= 0) begin
          checks++;
          if (obs_cnt[c] !== ecnt[CW-1:0]) begin
            errors++; $display("FAIL random_count it=%0d c=%0d got %0d exp %0d", it, c, obs_cnt[c], ecnt);
          end
        end
      end
      rearm();
    end
  endtask

  task automatic test_async_reset();
    int k;
    bus.I_delay = DW'(2); bus.I_width = PW'(4);
    bus.I_gap = DW'(3); bus.I_num_pulses = CW'(3);
    bus.I_match = 1'b1;
    @(posedge fe_clk); #1;
    bus.I_match = 1'b0;
    k = 0;
    @(negedge fe_clk);
    while (bus.O_trigger !== 1'b1 && k < 20) begin
      @(negedge fe_clk); k++;
    end
    checks++;
    if (bus.O_trigger !== 1'b1) begin
      errors++; $display("FAIL async_reset timeout waiting for trigger got %b exp 1", bus.O_trigger);
    end
    // Assert reset between edges, mid-pulse.
    #2 reset_i = 1'b1;
    #1;
    checks++;
    if ({bus.O_trigger, bus.O_busy, bus.O_done, bus.O_pulse_count} !== '0) begin
      errors++;
      $display("FAIL async_reset outputs got %b%b%b cnt=%0d exp 000 cnt=0",
               bus.O_trigger, bus.O_busy, bus.O_done, bus.O_pulse_count);
    end
    @(posedge fe_clk); #1;
    reset_i = 1'b0;
    // From IDLE a match is ignored even with arm high.
    bus.I_match = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge fe_clk);
      checks++;
      if (bus.O_trigger !== 1'b0 || bus.O_busy !== 1'b0) begin
        errors++; $display("FAIL post_reset_idle c=%0d got trig=%b busy=%b exp 0 0",
                           c, bus.O_trigger, bus.O_busy);
      end
      @(posedge fe_clk); #1;
      bus.I_match = 1'b0;
    end
  endtask

  initial begin
    bus.I_arm = 1'b0; bus.I_match = 1'b0;
    bus.I_delay = '0; bus.I_width = '0; bus.I_gap = '0; bus.I_num_pulses = '0;
    test_reset();
    rearm();
    test_single_pulse();
    test_zero();
    test_train();
    test_back_to_back();
    test_abort();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
